sha256_padder: RTL

Message front-end for the SHA-256 hashing datapath. It accepts a byte-aligned message as a stream of 32-bit words and applies FIPS 180-4 padding: a 0x80 marker, zero fill, and a 64-bit big-endian bit length. It emits complete 512-bit message blocks with valid/ready, in the word order the round pipeline consumes (W0 in bits [31:0]). The downstream controller uses `m_first` to select IV vs. chaining state and `m_last` to select the final digest.

---
 rtl/sha256_padder_if.sv | 24 ++
 rtl/sha256_padder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sha256_padder_if.sv
// Stream bundle for the SHA-256 padder: 32-bit message words in, 512-bit padded blocks out.
// The padder takes the slave view; the producer/consumer side takes the master view.
interface sha256_padder_if;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_ready;
    logic         s_last;
    logic [1:0]   s_bytes;
    logic [511:0] m_block;
    logic         m_valid;
    logic         m_ready;
    logic         m_first;
    logic         m_last;

    modport master (
        output s_data, s_valid, s_last, s_bytes, m_ready,
        input  s_ready, m_block, m_valid, m_first, m_last
    );

    modport slave (
        input  s_data, s_valid, s_last, s_bytes, m_ready,
        output s_ready, m_block, m_valid, m_first, m_last
    );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: marker, zero fill and 64-bit bit length, emitted as 512-bit blocks.
// Optional SHA256_PADDER_BYTESWAP_EN takes the first message byte from s_data[7:0].
module sha256_padder #(
    parameter int LEN_W = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    sha256_padder_if.slave bus
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t            state_r, state_n;
    state_t            ret_r, ret_n;
    logic [31:0]       buf_r [16];
    logic [4:0]        widx_r, widx_n;
    logic              pending_r, pending_n;
    logic              first_r, first_n;
    logic              last_blk_r, last_blk_n;
    logic [LEN_W-1:0]  bitlen_r, bitlen_n;
    logic              m_valid_r, m_first_r, m_last_r;

    logic [31:0]       din_s;
    logic [63:0]       len_s;
    logic              s_ready_s;
    logic              wr_en_s;
    logic              len_wr_s;
    logic [3:0]        wr_idx_s;
    logic [31:0]       wr_data_s;
    logic [511:0]      blk_s;

    // Keep the valid leading bytes of the final word and place the 0x80 marker right after them.
    function automatic logic [31:0] mark_last(input logic [31:0] w, input logic [1:0] nb);
        logic [31:0] r;
        case (nb)
            2'd1:    r = {w[31:24], 8'h80, 16'h0000};
            2'd2:    r = {w[31:16], 8'h80, 8'h00};
            2'd3:    r = {w[31:8], 8'h80};
            default: r = w;
        endcase
        return r;
    endfunction

`ifdef SHA256_PADDER_BYTESWAP_EN
    // Byte-reverse incoming words so the first message byte ends up in [31:24].
    always_comb din_s = {bus.s_data[7:0], bus.s_data[15:8], bus.s_data[23:16], bus.s_data[31:24]};
`else
    // Words are already MSB-first.
    always_comb din_s = bus.s_data;
`endif

    // Length field is the zero-extended bit counter.
    always_comb len_s = 64'(bitlen_r);

    // Input is accepted only in FILL and never while reset is held.
    always_comb s_ready_s = rst_n && (state_r == FILL);

    // Next-state and buffer-write decode.
    always_comb begin
        state_n    = state_r;
        ret_n      = ret_r;
        widx_n     = widx_r;
        pending_n  = pending_r;
        first_n    = first_r;
        last_blk_n = last_blk_r;
        bitlen_n   = bitlen_r;
        wr_en_s    = 1'b0;
        len_wr_s   = 1'b0;
        wr_idx_s   = widx_r[3:0];
        wr_data_s  = 32'h0000_0000;
        case (state_r)
            FILL: begin
                if (s_ready_s && bus.s_valid) begin
                    wr_en_s = 1'b1;
                    widx_n  = widx_r + 5'd1;
                    if (bus.s_last && (bus.s_bytes != 2'd0)) begin
                        bitlen_n = bitlen_r + LEN_W'({bus.s_bytes, 3'b000});
                    end else begin
                        bitlen_n = bitlen_r + LEN_W'(32'd32);
                    end
                    if (bus.s_last) begin
                        wr_data_s = mark_last(din_s, bus.s_bytes);
                        pending_n = (bus.s_bytes == 2'd0);
                        ret_n     = PAD;
                    end else begin
                        wr_data_s = din_s;
                        ret_n     = FILL;
                    end
                    // A full buffer is always emitted first; padding resumes afterwards.
                    if (widx_r == 5'd15) begin
                        state_n = EMIT;
                        widx_n  = 5'd0;
                    end else if (bus.s_last) begin
                        state_n = PAD;
                    end else begin
                        state_n = FILL;
                    end
                end else begin
                    state_n = FILL;
                end
            end
            PAD: begin
                if (!pending_r && (widx_r == 5'd14)) begin
                    len_wr_s   = 1'b1;
                    last_blk_n = 1'b1;
                    state_n    = EMIT;
                end else begin
                    wr_en_s   = 1'b1;
                    wr_data_s = pending_r ? 32'h8000_0000 : 32'h0000_0000;
                    pending_n = 1'b0;
                    if (widx_r == 5'd15) begin
                        state_n = EMIT;
                        ret_n   = PAD;
                        widx_n  = 5'd0;
                    end else begin
                        widx_n  = widx_r + 5'd1;
                    end
                end
            end
            EMIT: begin
                if (bus.m_ready) begin
                    if (last_blk_r) begin
                        // Message complete: rearm for the next message's first block.
                        bitlen_n   = {LEN_W{1'b0}};
                        first_n    = 1'b1;
                        last_blk_n = 1'b0;
                        widx_n     = 5'd0;
                        state_n    = FILL;
                    end else begin
                        first_n    = 1'b0;
                        state_n    = ret_r;
                    end
                end else begin
                    state_n = EMIT;
                end
            end
            default: begin
                state_n = FILL;
            end
        endcase
    end

    // FSM state, control flags and registered block qualifiers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= FILL;
            ret_r      <= FILL;
            widx_r     <= 5'd0;
            pending_r  <= 1'b0;
            first_r    <= 1'b1;
            last_blk_r <= 1'b0;
            bitlen_r   <= {LEN_W{1'b0}};
            m_valid_r  <= 1'b0;
            m_first_r  <= 1'b0;
            m_last_r   <= 1'b0;
        end else begin
            state_r    <= state_n;
            ret_r      <= ret_n;
            widx_r     <= widx_n;
            pending_r  <= pending_n;
            first_r    <= first_n;
            last_blk_r <= last_blk_n;
            bitlen_r   <= bitlen_n;
            m_valid_r  <= (state_n == EMIT);
            m_first_r  <= (state_n == EMIT) && first_n;
            m_last_r   <= (state_n == EMIT) && last_blk_n;
        end
    end

    // Block buffer; it is never written in EMIT, so it doubles as the held output block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                buf_r[i] <= 32'h0000_0000;
            end
        end else if (len_wr_s) begin
            buf_r[14] <= len_s[63:32];
            buf_r[15] <= len_s[31:0];
        end else if (wr_en_s) begin
            buf_r[wr_idx_s] <= wr_data_s;
        end else begin
            buf_r[wr_idx_s] <= buf_r[wr_idx_s];
        end
    end

    // Flatten the buffer with W0 in the low bits.
    always_comb begin
        blk_s = {512{1'b0}};
        for (int i = 0; i < 16; i++) begin
            blk_s[32*i +: 32] = buf_r[i];
        end
    end

    assign bus.s_ready = s_ready_s;
    assign bus.m_block = blk_s;
    assign bus.m_valid = m_valid_r;
    assign bus.m_first = m_first_r;
    assign bus.m_last  = m_last_r;

endmodule
